// File: rtl/fft_input_pkg.sv
// Shared sizing, types and the bit-reverse helper for the FFT input ping-pong buffer.
package fft_input_pkg;

    localparam int SIZE             = 16;
    localparam int SAMPLES          = 2048;
    localparam int INPUT_SIZE       = 512;
    localparam int SAMPLES_PER_LINE = INPUT_SIZE / SIZE;
    localparam int LINES            = SAMPLES / SAMPLES_PER_LINE;

    localparam int IDX_W  = $clog2(SAMPLES);
    localparam int SPL_W  = $clog2(SAMPLES_PER_LINE);
    localparam int LPTR_W = $clog2(LINES);

    typedef logic [SIZE-1:0]   sample_t;
    typedef logic [LPTR_W-1:0] line_ptr_t;
    typedef logic [IDX_W-1:0]  sample_idx_t;

    function automatic sample_idx_t bitrev(input sample_idx_t idx);
        sample_idx_t r;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = idx[IDX_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_input_bank.sv
// One frame bank: line-wide write port, registered single-sample read port.
module fft_input_bank
    import fft_input_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [LPTR_W-1:0]     wr_line,
    input  logic [INPUT_SIZE-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_addr,
    output logic [SIZE-1:0]       rd_data
);

    logic [INPUT_SIZE-1:0] mem [LINES];
    logic [INPUT_SIZE-1:0] rd_line;
    logic [SPL_W-1:0]      rd_lane;

    // Upper index bits select the line, lower bits the sample lane inside it.
    assign rd_line = mem[rd_addr[IDX_W-1 -: LPTR_W]];
    assign rd_lane = rd_addr[SPL_W-1:0];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_line] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_line[SIZE*int'(rd_lane) +: SIZE];
        end
    end

endmodule

// File: rtl/fft_input_pingpong.sv
// Ping-pong sample buffer between DMA line writes and FFT sample reads.
// Define FFT_INPUT_BITREV_EN to bit-reverse the read index.
module fft_input_pingpong
    import fft_input_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INPUT_SIZE-1:0] data_in,
    output logic                  frame_ready,
    output logic [1:0]            frames_full,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_index,
    output logic [SIZE-1:0]       data_out,
    output logic                  rd_valid,
    input  logic                  frame_release
);

    logic        wr_bank;
    logic        rd_bank;
    line_ptr_t   line_ptr;
    logic [1:0]  full;
    logic [1:0]  full_nxt;
    logic        rd_sel;
    logic        run;
    logic        xfer;
    logic        rel;
    logic        rd_fire;
    logic        last_line;
    sample_idx_t rd_addr;
    sample_t     bank_q [2];

    assign in_ready    = !full[wr_bank];
    assign frame_ready = full[rd_bank];
    assign frames_full = {1'b0, full[0]} + {1'b0, full[1]};

    // flush behaves like reset for every input-driven action in its cycle.
    assign run       = rst_n && !flush;
    assign xfer      = run && in_valid && in_ready;
    assign rel       = run && frame_release && frame_ready;
    assign rd_fire   = run && rd_en && frame_ready;
    assign last_line = (line_ptr == line_ptr_t'(LINES - 1));

`ifdef FFT_INPUT_BITREV_EN
    assign rd_addr = bitrev(rd_index);
`else
    assign rd_addr = rd_index;
`endif

    // Completion and release always hit different banks, so both may apply.
    always_comb begin
        full_nxt = full;
        if (xfer && last_line) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (rel) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!run) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            line_ptr <= '0;
            full     <= '0;
            rd_valid <= 1'b0;
        end else begin
            full     <= full_nxt;
            rd_valid <= rd_fire;
            if (xfer) begin
                line_ptr <= line_ptr + 1'b1;
                if (last_line) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (rel) begin
                rd_bank <= !rd_bank;
            end
        end
    end

    // Output mux follows the bank that served the last read so data_out holds across flush.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_sel <= 1'b0;
        end else if (rd_fire) begin
            rd_sel <= rd_bank;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_input_bank u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (xfer && (wr_bank == 1'(b))),
            .wr_line (line_ptr),
            .wr_data (data_in),
            .rd_en   (rd_fire && (rd_bank == 1'(b))),
            .rd_addr (rd_addr),
            .rd_data (bank_q[b])
        );
    end

    assign data_out = bank_q[rd_sel];

endmodule

// File: tb/tb_fft_input_pingpong.sv
// Directed bench for fft_input_pingpong; expectations follow FFT_INPUT_BITREV_EN when defined.
module tb_fft_input_pingpong;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [511:0] data_in = '0;
    logic         frame_ready;
    logic [1:0]   frames_full;
    logic         rd_en = 1'b0;
    logic [10:0]  rd_index = '0;
    logic [15:0]  data_out;
    logic         rd_valid;
    logic         frame_release = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_data;

    fft_input_pingpong dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .data_in       (data_in),
        .frame_ready   (frame_ready),
        .frames_full   (frames_full),
        .rd_en         (rd_en),
        .rd_index      (rd_index),
        .data_out      (data_out),
        .rd_valid      (rd_valid),
        .frame_release (frame_release)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] make_line(input logic [15:0] first);
        logic [511:0] l;
        for (int k = 0; k < 32; k++) begin
            l[16*k +: 16] = first + 16'(k);
        end
        return l;
    endfunction

    // Which stored sample a given rd_index addresses.
    function automatic logic [15:0] exp_idx(input logic [10:0] idx);
`ifdef FFT_INPUT_BITREV_EN
        logic [10:0] r;
        for (int i = 0; i < 11; i++) r[i] = idx[10-i];
        return {5'd0, r};
`else
        return {5'd0, idx};
`endif
    endfunction

    task automatic push_line(input logic [15:0] first);
        bit done = 0;
        data_in  = make_line(first);
        in_valid = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            done = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!done) check_eq("push_timeout", 0, 1);
    endtask

    task automatic push_frame(input logic [15:0] base, input int from_line, input int to_line);
        for (int l = from_line; l <= to_line; l++) begin
            push_line(base + 16'(l * 32));
        end
    endtask

    task automatic read_chk(input string tag, input logic [10:0] idx, input logic [15:0] exp);
        rd_en    = 1'b1;
        rd_index = idx;
        tick();
        rd_en = 1'b0;
        check_eq({tag, "_vld"}, rd_valid, 1);
        check_eq(tag, data_out, exp);
        last_data = exp;
    endtask

    initial begin
        // Reset values
        tick(); tick();
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_frame_ready", frame_ready, 0);
        check_eq("rst_frames_full", frames_full, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_data_out", data_out, 0);
        rst_n = 1'b1;
        tick();

        // Ramp frame into bank 0; frame_ready must not rise before line 63
        push_frame(16'h0000, 0, 62);
        check_eq("f0_not_ready_62", frame_ready, 0);
        push_frame(16'h0000, 63, 63);
        check_eq("f0_ready", frame_ready, 1);
        check_eq("f0_full_cnt", frames_full, 1);
        check_eq("f0_in_ready", in_ready, 1);
        read_chk("rd_0", 11'd0, exp_idx(11'd0));
        read_chk("rd_31", 11'd31, exp_idx(11'd31));
        read_chk("rd_32", 11'd32, exp_idx(11'd32));
        read_chk("rd_2047", 11'd2047, exp_idx(11'd2047));
        // Back-to-back reads
        rd_en = 1'b1; rd_index = 11'd5;
        tick();
        check_eq("b2b_a", data_out, exp_idx(11'd5));
        rd_index = 11'd6;
        tick();
        check_eq("b2b_b", data_out, exp_idx(11'd6));
        check_eq("b2b_vld", rd_valid, 1);
        rd_en = 1'b0;
        tick();
        check_eq("idle_vld", rd_valid, 0);
        check_eq("idle_hold", data_out, exp_idx(11'd6));

        // Bank 1 completes in the same cycle bank 0 is released (with a read of bank 0)
        push_frame(16'h4000, 0, 62);
        check_eq("f1_pre_cnt", frames_full, 1);
        data_in = make_line(16'h4000 + 16'(63 * 32));
        in_valid = 1'b1; frame_release = 1'b1; rd_en = 1'b1; rd_index = 11'd7;
        tick();
        in_valid = 1'b0; frame_release = 1'b0; rd_en = 1'b0;
        check_eq("sim_cnt", frames_full, 1);
        check_eq("sim_ready", frame_ready, 1);
        check_eq("sim_in_ready", in_ready, 1);
        check_eq("rel_rd_vld", rd_valid, 1);
        check_eq("rel_rd_data", data_out, exp_idx(11'd7));
        read_chk("f1_rd_0", 11'd0, 16'h4000 + exp_idx(11'd0));
        read_chk("f1_rd_2047", 11'd2047, 16'h4000 + exp_idx(11'd2047));

        // Fill bank 0 so both banks are full; held line must wait for a release
        push_frame(16'h8000, 0, 63);
        check_eq("both_in_ready", in_ready, 0);
        check_eq("both_cnt", frames_full, 2);
        data_in = make_line(16'hC000);
        in_valid = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        check_eq("stall_in_ready", in_ready, 0);
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
        check_eq("unstall_in_ready", in_ready, 1);
        check_eq("unstall_cnt", frames_full, 1);
        tick();
        in_valid = 1'b0;
        check_eq("held_cnt", frames_full, 1);
        read_chk("f2_rd_100", 11'd100, 16'h8000 + exp_idx(11'd100));
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
        check_eq("empty_ready", frame_ready, 0);
        check_eq("empty_cnt", frames_full, 0);

        // Read and release with no frame available
        rd_en = 1'b1; rd_index = 11'd0;
        tick();
        rd_en = 1'b0;
        check_eq("nf_rd_vld", rd_valid, 0);
        check_eq("nf_rd_hold", data_out, last_data);
        frame_release = 1'b1;
        tick();
        frame_release = 1'b0;
        check_eq("nf_rel_cnt", frames_full, 0);
        push_frame(16'hC000, 1, 63);
        check_eq("f3_ready", frame_ready, 1);
        read_chk("f3_rd_0", 11'd0, 16'hC000 + exp_idx(11'd0));
        read_chk("f3_rd_33", 11'd33, 16'hC000 + exp_idx(11'd33));

        // Flush mid-frame (with competing inputs) discards the partial frame
        push_frame(16'h1111, 0, 39);
        data_in = make_line(16'hEEEE);
        in_valid = 1'b1; rd_en = 1'b1; frame_release = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; rd_en = 1'b0; frame_release = 1'b0; flush = 1'b0;
        check_eq("fl_in_ready", in_ready, 1);
        check_eq("fl_ready", frame_ready, 0);
        check_eq("fl_cnt", frames_full, 0);
        check_eq("fl_vld", rd_valid, 0);
        check_eq("fl_hold", data_out, last_data);
        push_frame(16'h2000, 0, 62);
        check_eq("fl_not_ready_62", frame_ready, 0);
        push_frame(16'h2000, 63, 63);
        check_eq("fl_frame_ready", frame_ready, 1);
        check_eq("fl_frame_cnt", frames_full, 1);
        read_chk("fl_rd_0", 11'd0, 16'h2000 + exp_idx(11'd0));
        read_chk("fl_rd_1285", 11'd1285, 16'h2000 + exp_idx(11'd1285));
        read_chk("fl_rd_2047", 11'd2047, 16'h2000 + exp_idx(11'd2047));
`ifdef FFT_INPUT_BITREV_EN
        read_chk("order_1", 11'd1, 16'h2000 + 16'd1024);
        read_chk("order_3", 11'd3, 16'h2000 + 16'd1536);
`else
        read_chk("order_1", 11'd1, 16'h2000 + 16'd1);
        read_chk("order_3", 11'd3, 16'h2000 + 16'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fft_input_pingpong.md
Name: fft_input_pingpong

Overview:
- Double-buffered (ping-pong) sample buffer between the DMA read path and the FFT core.
- The DMA side streams INPUT_SIZE-bit lines through a valid/ready handshake. Each line carries SAMPLES_PER_LINE packed samples.
- The FFT side random-reads SIZE-bit samples from the completed frame while the other bank fills.
- Generalises the single-bank, externally-indexed input buffer with auto line addressing, frame tracking, backpressure and registered reads.

Parameters:
- SIZE, 16, bits per sample.
- SAMPLES, 2048, samples per frame (power of two).
- INPUT_SIZE, 512, bits per DMA line; must be a multiple of SIZE.
- Derived localparams:
  - SAMPLES_PER_LINE = INPUT_SIZE/SIZE (32).
  - LINES = SAMPLES/SAMPLES_PER_LINE (64).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- flush  in  1  synchronous clear of pointers and flags.
- in_valid  in  1  data_in holds a line.
- in_ready  out  1  buffer accepts a line this cycle.
- data_in  in  INPUT_SIZE  packed line.
- frame_ready  out  1  read bank holds a complete frame.
- frames_full  out  2  count of completed, unreleased frames (0..2).
- rd_en  in  1  read request.
- rd_index  in  $clog2(SAMPLES)  sample index to read.
- data_out  out  SIZE  read data.
- rd_valid  out  1  data_out valid.
- frame_release  in  1  consumer done with the read bank.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values:
  - wr_bank=0, rd_bank=0, line_ptr=0, full[1:0]=0.
  - in_ready=1, frame_ready=0, frames_full=0, rd_valid=0, data_out=0.
  - Sample memory is not reset.
- flush: same effect as reset on all state except data_out, which holds its value. flush has priority over every other input that cycle.
- Line packing: sample k of a line = data_in[SIZE*k +: SIZE], bytes little-endian. Line L fills samples L*SAMPLES_PER_LINE .. L*SAMPLES_PER_LINE+SAMPLES_PER_LINE-1 of bank wr_bank.
- Write handshake:
  - in_ready = !full[wr_bank] (combinational).
  - A transfer occurs when in_valid && in_ready. It writes the line and increments line_ptr.
  - On a transfer with line_ptr==LINES-1: set full[wr_bank], toggle wr_bank, line_ptr wraps to 0.
  - in_valid while !in_ready: no effect. The producer holds the data; nothing is dropped.
- frame_ready = full[rd_bank]. frames_full = full[0]+full[1].
- Read:
  - rd_en && frame_ready: data_out <= bank[rd_bank][rd_index] and rd_valid <= 1 on the next edge. Latency is 1 cycle; back-to-back reads are allowed every cycle.
  - rd_en && !frame_ready: rd_valid <= 0 and data_out holds.
  - !rd_en: rd_valid <= 0.
- Release:
  - frame_release && frame_ready: clear full[rd_bank], toggle rd_bank.
  - frame_release while !frame_ready is ignored.
  - A read in the same cycle as a release still returns data from the bank being released.
- Simultaneous events:
  - Frame completion on one bank and release of the other bank in the same cycle: both take effect.
  - Release of the bank the writer is stalled on: in_ready rises the next cycle.
- Both banks full: in_ready=0 until a release.
- Reset or flush mid-frame discards the partial frame; the next accepted line is line 0 of bank 0.

Optional Feature:
- Macro FFT_INPUT_BITREV_EN.
- Defined: the read address is bit-reversed over $clog2(SAMPLES) bits, so data_out = bank[rd_bank][bitrev(rd_index)]. The FFT reads in natural order and receives bit-reversed input order. Latency is unchanged.
- Undefined: natural-order addressing, with no extra logic.

Decomposition:
- Package fft_input_pkg:
  - Localparams SIZE, SAMPLES, INPUT_SIZE, SAMPLES_PER_LINE, LINES.
  - typedef sample_t (logic [SIZE-1:0]).
  - typedef line_ptr_t and sample_idx_t.
  - Function bitrev(sample_idx_t).
- Sub-module fft_input_bank: one bank with a line-wide write port (write enable, line index, line data) and a registered single-sample read port. It is instantiated twice; the top selects data_out by rd_bank.

Test Plan:
- Reset, then 64 lines where sample k of line L = L*32+k -> frame_ready=1 and frames_full=1 after the 64th transfer. Reads at index 0, 31, 32, 2047 return 0, 31, 32, 2047 one cycle later with rd_valid=1.
- Stream 128 lines with no release -> in_ready=0 after the 128th transfer and frames_full=2. A 129th line held on in_valid is accepted one cycle after frame_release, landing in bank 0 line 0.
- rd_en with frame_ready=0 -> rd_valid=0 and data_out unchanged. frame_release with frame_ready=0 -> rd_bank unchanged.
- Frame 1 completes (line 63 of bank 1) in the same cycle frame_release clears bank 0 -> frames_full stays 1, rd_bank=1, frame_ready=1.
- flush after 40 lines -> line_ptr=0, in_ready=1, frame_ready=0. The next 64 lines form a clean frame in bank 0.
- With FFT_INPUT_BITREV_EN and a ramp frame, rd_index=1 returns 1024 and rd_index=3 returns 1536. Without the macro they return 1 and 3.
